// File: rtl/cond_flag_if.sv
// Flag-unit bus: decoder/ALU controls in, gated write enables and stored flags out.
// The snapshot signals exist only when COND_FLAG_SNAPSHOT_EN is defined.
interface cond_flag_if;
  logic [3:0] Cond;
  logic [4:0] ALUFlags;
  logic [1:0] FlagW;
  logic       QFlagClr;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;
  logic       QFlag;
  logic       curr_carry_flag;
`ifdef COND_FLAG_SNAPSHOT_EN
  logic       FlagSave;
  logic       FlagRestore;
  logic       SnapValid;

  modport master (
    output Cond, ALUFlags, FlagW, QFlagClr, PCS, RegW, MemW, NoWrite, Stall,
           FlagSave, FlagRestore,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, QFlag, curr_carry_flag,
           SnapValid
  );
  modport slave (
    input  Cond, ALUFlags, FlagW, QFlagClr, PCS, RegW, MemW, NoWrite, Stall,
           FlagSave, FlagRestore,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, QFlag, curr_carry_flag,
           SnapValid
  );
`else
  modport master (
    output Cond, ALUFlags, FlagW, QFlagClr, PCS, RegW, MemW, NoWrite, Stall,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, QFlag, curr_carry_flag
  );
  modport slave (
    input  Cond, ALUFlags, FlagW, QFlagClr, PCS, RegW, MemW, NoWrite, Stall,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, QFlag, curr_carry_flag
  );
`endif
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural N/Z/C/V + sticky Q flag register with ARM-style condition gating.
// Optional one-entry flag snapshot enabled by defining COND_FLAG_SNAPSHOT_EN.
module cond_flag_unit #(
  parameter int         NUM_COND    = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  cond_flag_if.slave  bus
);
  localparam int COND_W = $clog2(NUM_COND);

  logic [COND_W-1:0] cond_sel;
  logic [3:0]        flags_reg, flags_next, flags_upd;
  logic              q_reg, q_next;
  logic              cond_ex;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              upd_en;
  logic              restore_en;

  assign cond_sel = bus.Cond;
  assign flag_n   = flags_reg[3];
  assign flag_z   = flags_reg[2];
  assign flag_c   = flags_reg[1];
  assign flag_v   = flags_reg[0];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_sel)
      4'd0:    cond_ex = flag_z;
      4'd1:    cond_ex = ~flag_z;
      4'd2:    cond_ex = flag_c;
      4'd3:    cond_ex = ~flag_c;
      4'd4:    cond_ex = flag_n;
      4'd5:    cond_ex = ~flag_n;
      4'd6:    cond_ex = flag_v;
      4'd7:    cond_ex = ~flag_v;
      4'd8:    cond_ex = flag_c & ~flag_z;
      4'd9:    cond_ex = ~flag_c | flag_z;
      4'd10:   cond_ex = (flag_n == flag_v);
      4'd11:   cond_ex = (flag_n != flag_v);
      4'd12:   cond_ex = ~flag_z & (flag_n == flag_v);
      4'd13:   cond_ex = flag_z | (flag_n != flag_v);
      4'd14:   cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Stall deliberately does not mask the write enables; hazard logic handles that.
  assign bus.CondEx          = cond_ex;
  assign bus.PCSrc           = bus.PCS  & cond_ex;
  assign bus.MemWrite        = bus.MemW & cond_ex;
  assign bus.RegWrite        = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.Flags           = flags_reg;
  assign bus.QFlag           = q_reg;
  assign bus.curr_carry_flag = flags_reg[1];

  assign upd_en = cond_ex & ~bus.Stall;

  // FlagW[1] owns {N,Z}, FlagW[0] owns {C,V}; each half loads independently.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign flags_upd[2*gi+1:2*gi] = (upd_en & bus.FlagW[gi]) ?
                                      bus.ALUFlags[2*gi+1:2*gi] :
                                      flags_reg[2*gi+1:2*gi];
    end
  endgenerate

`ifdef COND_FLAG_SNAPSHOT_EN
  logic [4:0] shadow_reg, shadow_next;
  logic       snap_valid_reg, snap_valid_next;
  logic       save_en;

  assign save_en       = bus.FlagSave & ~bus.Stall;
  assign restore_en    = bus.FlagRestore & ~bus.Stall & snap_valid_reg;
  assign bus.SnapValid = snap_valid_reg;

  // A simultaneous save captures the pre-restore state, so the entry stays valid.
  always_comb begin
    shadow_next     = shadow_reg;
    snap_valid_next = snap_valid_reg;
    if (save_en) begin
      shadow_next     = {q_reg, flags_reg};
      snap_valid_next = 1'b1;
    end else if (restore_en) begin
      snap_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_reg     <= 5'b00000;
      snap_valid_reg <= 1'b0;
    end else begin
      shadow_reg     <= shadow_next;
      snap_valid_reg <= snap_valid_next;
    end
  end
`else
  logic [4:0] shadow_reg;

  assign restore_en = 1'b0;
  assign shadow_reg = 5'b00000;
`endif

  // Q set beats clear; a snapshot restore beats both the flag and Q updates.
  always_comb begin
    flags_next = flags_upd;
    q_next     = q_reg;
    if (bus.QFlagClr & ~bus.Stall) q_next = 1'b0;
    if (upd_en & bus.ALUFlags[4])  q_next = 1'b1;
    if (restore_en) begin
      q_next     = shadow_reg[4];
      flags_next = shadow_reg[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_reg <= RESET_FLAGS;
      q_reg     <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      q_reg     <= q_next;
    end
  end
endmodule
